// File: rtl/revfetch_pkg.sv
// Shared types and constants for the revision fetcher: FSM states, AXI read
// response codes and the index of each field in the revision register file.
package revfetch_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    AR    = 2'd1,
    R     = 2'd2,
    DRAIN = 2'd3
  } fetch_state_e;

  localparam logic [1:0] OKAY   = 2'b00;
  localparam logic [1:0] SLVERR = 2'b10;

  localparam int unsigned REG_MAJOR   = 0;
  localparam int unsigned REG_MINOR   = 1;
  localparam int unsigned REG_BUILD   = 2;
  localparam int unsigned REG_RC      = 3;
  localparam int unsigned REG_DATE    = 4;
  localparam int unsigned REG_TYPE    = 5;
  localparam int unsigned REG_SUBTYPE = 6;

  function automatic logic resp_ok(input logic [1:0] resp);
    return resp == OKAY;
  endfunction

endpackage

// File: rtl/revfetch_watchdog.sv
// Read-data watchdog for the revision fetcher; exists only when
// REVFETCH_TIMEOUT_EN is defined.
`ifdef REVFETCH_TIMEOUT_EN
module revfetch_watchdog #(
  parameter int unsigned LIMIT = 256
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic expired
);

  localparam int unsigned CW = $clog2(LIMIT + 1);

  logic [CW-1:0] cnt_q, cnt_d;

  assign expired = (cnt_q == CW'(LIMIT));

  // Saturates at LIMIT so expired stays high until the next clear.
  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en && !expired) begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule
`endif

// File: rtl/revision_fetcher.sv
// AXI4-Lite read-only master that fetches the build-revision registers after
// reset or on start. Optional read watchdog: define REVFETCH_TIMEOUT_EN.
module revision_fetcher
  import revfetch_pkg::*;
#(
  parameter int unsigned                AXI_ADDR_WIDTH = 32,
  parameter logic [AXI_ADDR_WIDTH-1:0]  BASE_ADDR      = '0,
  parameter int unsigned                REG_COUNT      = 7,
  parameter int unsigned                TIMEOUT_CYCLES = 256
) (
  input  logic                        AXI_ACLK,
  input  logic                        AXI_ARESETN,
  input  logic                        start,
  output logic [AXI_ADDR_WIDTH-1:0]   M_AXI_ARADDR,
  output logic                        M_AXI_ARVALID,
  output logic [2:0]                  M_AXI_ARPROT,
  input  logic                        M_AXI_ARREADY,
  input  logic [31:0]                 M_AXI_RDATA,
  input  logic [1:0]                  M_AXI_RRESP,
  input  logic                        M_AXI_RVALID,
  output logic                        M_AXI_RREADY,
  output logic [REG_COUNT*32-1:0]     rev_regs,
  output logic                        busy,
  output logic                        done,
  output logic                        error,
`ifdef REVFETCH_TIMEOUT_EN
  output logic                        timeout,
`endif
  output logic [2:0]                  err_index
);

  localparam logic [2:0] LAST_IDX = 3'(REG_COUNT - 1);

  fetch_state_e            state_q, state_d;
  logic [2:0]              idx_q, idx_d;
  logic [REG_COUNT*32-1:0] rev_regs_q, rev_regs_d;
  logic                    busy_q, busy_d;
  logic                    done_q, done_d;
  logic                    error_q, error_d;
  logic [2:0]              err_index_q, err_index_d;
  logic                    timeout_q, timeout_d;
  logic                    auto_q, auto_d;
  logic                    arvalid, rready;

`ifdef REVFETCH_TIMEOUT_EN
  logic wd_clr, wd_en, wd_expired;

  revfetch_watchdog #(
    .LIMIT (TIMEOUT_CYCLES)
  ) u_watchdog (
    .clk     (AXI_ACLK),
    .rst_n   (AXI_ARESETN),
    .clr     (wd_clr),
    .en      (wd_en),
    .expired (wd_expired)
  );
`endif

  // auto_q is a one-shot that launches the first fetch after reset release.
  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    rev_regs_d  = rev_regs_q;
    busy_d      = busy_q;
    done_d      = done_q;
    error_d     = error_q;
    err_index_d = err_index_q;
    timeout_d   = timeout_q;
    auto_d      = auto_q;
    arvalid     = 1'b0;
    rready      = 1'b0;
`ifdef REVFETCH_TIMEOUT_EN
    wd_clr      = 1'b0;
    wd_en       = 1'b0;
`endif
    case (state_q)
      IDLE: begin
        if (start || auto_q) begin
          auto_d    = 1'b0;
          done_d    = 1'b0;
          error_d   = 1'b0;
          timeout_d = 1'b0;
          idx_d     = 3'(REG_MAJOR);
          busy_d    = 1'b1;
          state_d   = AR;
        end
      end
      AR: begin
        arvalid = 1'b1;
        if (M_AXI_ARREADY) begin
          state_d = R;
`ifdef REVFETCH_TIMEOUT_EN
          wd_clr  = 1'b1;
`endif
        end
      end
      R: begin
        rready = 1'b1;
`ifdef REVFETCH_TIMEOUT_EN
        wd_en  = 1'b1;
`endif
        if (M_AXI_RVALID) begin
          if (resp_ok(M_AXI_RRESP)) begin
            for (int i = 0; i < REG_COUNT; i++) begin
              if (idx_q == 3'(i)) rev_regs_d[i*32 +: 32] = M_AXI_RDATA;
            end
            if (idx_q == LAST_IDX) begin
              done_d  = 1'b1;
              busy_d  = 1'b0;
              state_d = IDLE;
            end else begin
              idx_d   = idx_q + 3'd1;
              state_d = AR;
            end
          end else begin
            // Failing slot and later slots keep the previous fetch's values.
            error_d     = 1'b1;
            err_index_d = idx_q;
            busy_d      = 1'b0;
            state_d     = IDLE;
          end
        end
`ifdef REVFETCH_TIMEOUT_EN
        else if (wd_expired) begin
          error_d     = 1'b1;
          timeout_d   = 1'b1;
          err_index_d = idx_q;
          state_d     = DRAIN;
        end
`endif
      end
`ifdef REVFETCH_TIMEOUT_EN
      DRAIN: begin
        // The late beat is still owed to us; swallow it before going idle.
        rready = 1'b1;
        if (M_AXI_RVALID) begin
          busy_d  = 1'b0;
          state_d = IDLE;
        end
      end
`endif
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge AXI_ACLK or negedge AXI_ARESETN) begin
    if (!AXI_ARESETN) begin
      state_q     <= IDLE;
      idx_q       <= '0;
      rev_regs_q  <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      error_q     <= 1'b0;
      err_index_q <= '0;
      timeout_q   <= 1'b0;
      auto_q      <= 1'b1;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      rev_regs_q  <= rev_regs_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      error_q     <= error_d;
      err_index_q <= err_index_d;
      timeout_q   <= timeout_d;
      auto_q      <= auto_d;
    end
  end

  // idx only changes outside AR, so ARADDR is stable while ARVALID waits.
  assign M_AXI_ARADDR  = BASE_ADDR + AXI_ADDR_WIDTH'({idx_q, 2'b00});
  assign M_AXI_ARVALID = arvalid;
  assign M_AXI_ARPROT  = 3'b000;
  assign M_AXI_RREADY  = rready;
  assign rev_regs      = rev_regs_q;
  assign busy          = busy_q;
  assign done          = done_q;
  assign error         = error_q;
  assign err_index     = err_index_q;
`ifdef REVFETCH_TIMEOUT_EN
  assign timeout       = timeout_q;
`else
  logic unused_timeout;
  assign unused_timeout = timeout_q;
`endif

endmodule
